// File: rtl/mission_sequencer.sv
// mission_sequencer: robot mission FSM with waypoint buffer, gyro settle wait and tick divider.
// Define LOOP_MISSION_EN to make the waypoint list wrap to slot 0 (patrol mode) instead of finishing.
module mission_sequencer #(
  parameter int WAYPOINTS = 4,
  parameter int COORD_W   = 32,
  parameter int DELAY_W   = 32,
  parameter int TICK_W    = 8,
  localparam int IW       = $clog2(WAYPOINTS) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      robot_enable,
  input  logic                      abort,
  input  logic                      cfg_done,
  input  logic                      target_reached,
  input  logic [TICK_W-1:0]         tick_div,
  input  logic [DELAY_W-1:0]        gyro_delay,
  input  logic                      wp_wr,
  input  logic signed [COORD_W-1:0] wp_x,
  input  logic signed [COORD_W-1:0] wp_y,
  output logic                      cfg_req,
  output logic                      gyro_en,
  output logic                      ctrl_en,
  output logic                      telem_en,
  output logic                      tick_en,
  output logic signed [COORD_W-1:0] target_x,
  output logic signed [COORD_W-1:0] target_y,
  output logic [IW-1:0]             wp_index,
  output logic [IW-1:0]             wp_count,
  output logic                      wp_overflow,
  output logic                      mission_done,
  output logic [2:0]                state
);
  localparam int AW = WAYPOINTS > 1 ? $clog2(WAYPOINTS) : 1;
  localparam logic [2:0] IDLE = 3'd0, CONFIG = 3'd1, GYRO_WAIT = 3'd2, LOAD = 3'd3, RUN = 3'd4, DONE = 3'd5;
  logic [2*COORD_W-1:0] mem [2**AW];
  logic [TICK_W-1:0]    tick_cnt;
  logic [DELAY_W:0]     gyro_cnt;
  logic                 tr_q, tr_edge, wrap, load_ok;
  logic [AW-1:0]        load_slot;
  logic [2:0]           nxt;
  always_comb begin
    tr_edge = target_reached & ~tr_q;
`ifdef LOOP_MISSION_EN
    wrap = (wp_index == wp_count) && (wp_count != '0);
`else
    wrap = 1'b0;
`endif
    load_ok   = (wp_index < wp_count) || wrap;
    load_slot = wrap ? '0 : wp_index[AW-1:0];
    nxt = state;
    if (abort) nxt = DONE;
    else if (robot_enable)
      case (state)
        IDLE:      nxt = CONFIG;
        CONFIG:    nxt = cfg_done ? GYRO_WAIT : CONFIG;
        GYRO_WAIT: nxt = gyro_cnt > {1'b0, gyro_delay} ? LOAD : GYRO_WAIT;
        LOAD:      nxt = load_ok ? RUN : DONE;
        RUN:       nxt = tr_edge ? LOAD : RUN;
        default:   nxt = state;
      endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      tick_en      <= 1'b0;
      gyro_cnt     <= '0;
      tr_q         <= 1'b0;
      cfg_req      <= 1'b0;
      gyro_en      <= 1'b0;
      ctrl_en      <= 1'b0;
      telem_en     <= 1'b0;
      mission_done <= 1'b0;
      target_x     <= '0;
      target_y     <= '0;
      wp_index     <= '0;
      wp_count     <= '0;
      wp_overflow  <= 1'b0;
    end else begin
      tr_q         <= target_reached;
      tick_en      <= tick_cnt >= tick_div;
      tick_cnt     <= tick_cnt >= tick_div ? '0 : tick_cnt + 1'b1;
      state        <= nxt;
      cfg_req      <= nxt == CONFIG;
      mission_done <= nxt == DONE;
      ctrl_en      <= robot_enable && nxt == RUN;
      gyro_en      <= nxt == DONE ? 1'b0 : gyro_en | (nxt == GYRO_WAIT);
      telem_en     <= telem_en | (nxt == RUN) | (nxt == DONE);
      if (robot_enable && state == GYRO_WAIT) gyro_cnt <= gyro_cnt + 1'b1;
      if (abort) begin
        wp_count <= '0;
        wp_index <= '0;
      end else begin
        if (wp_wr && state != DONE) begin
          if (wp_count < IW'(WAYPOINTS)) begin
            mem[wp_count[AW-1:0]] <= {wp_x, wp_y};
            wp_count              <= wp_count + 1'b1;
          end else wp_overflow <= 1'b1;
        end
        if (robot_enable && state == LOAD && load_ok) begin
          {target_x, target_y} <= mem[load_slot];
          if (wrap) wp_index <= '0;
        end
        if (robot_enable && state == RUN && tr_edge) wp_index <= wp_index + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mission_sequencer.sv
// tb_mission_sequencer: scoreboard bench for mission_sequencer (default 4-waypoint build).
module tb_mission_sequencer;
  logic clk = 1'b0, reset = 1'b0, robot_enable = 1'b0, abort = 1'b0, cfg_done = 1'b0;
  logic target_reached = 1'b0, wp_wr = 1'b0;
  logic [7:0] tick_div = 8'd4;
  logic [31:0] gyro_delay = 32'd8;
  logic signed [31:0] wp_x = 0, wp_y = 0, target_x, target_y;
  logic cfg_req, gyro_en, ctrl_en, telem_en, tick_en, wp_overflow, mission_done;
  logic [2:0] wp_index, wp_count, state;
  int n_checks = 0, n_errors = 0;
  typedef struct { int x; int y; } tgt_t;
  tgt_t sb[$];

  mission_sequencer dut (
    .clk(clk), .reset(reset), .robot_enable(robot_enable), .abort(abort), .cfg_done(cfg_done),
    .target_reached(target_reached), .tick_div(tick_div), .gyro_delay(gyro_delay), .wp_wr(wp_wr),
    .wp_x(wp_x), .wp_y(wp_y), .cfg_req(cfg_req), .gyro_en(gyro_en), .ctrl_en(ctrl_en),
    .telem_en(telem_en), .tick_en(tick_en), .target_x(target_x), .target_y(target_y),
    .wp_index(wp_index), .wp_count(wp_count), .wp_overflow(wp_overflow),
    .mission_done(mission_done), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int x, input int y, input bit push);
    tgt_t t;
    wp_x = x; wp_y = y; wp_wr = 1'b1;
    step(1);
    wp_wr = 1'b0;
    t.x = x; t.y = y;
    if (push) sb.push_back(t);
  endtask

  task automatic wait_state(input string tag, input int st);
    int n = 0;
    while (state != 3'(st) && n < 60) begin step(1); n++; end
    check(tag, state, st);
  endtask

  task automatic expect_target(input string tag);
    tgt_t t;
    if (sb.size() == 0) check({tag, "_sb_empty"}, 0, 1);
    else begin
      t = sb.pop_front();
      check({tag, "_x"}, target_x, t.x);
      check({tag, "_y"}, target_y, t.y);
    end
  endtask

  task automatic pulse_tr;
    target_reached = 1'b1;
    step(1);
    target_reached = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b0; robot_enable = 1'b0; abort = 1'b0; cfg_done = 1'b0; target_reached = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  initial begin
    int n;
    step(2);
    check("rst_state", state, 0);
    check("rst_cfg_req", cfg_req, 0);
    check("rst_tick_en", tick_en, 0);
    check("rst_target_x", target_x, 0);
    check("rst_wp_count", wp_count, 0);
    check("rst_overflow", wp_overflow, 0);
    check("rst_done", mission_done, 0);
    reset = 1'b1;
    n = 0;
    while (!tick_en && n < 12) begin step(1); n++; end
    check("tick_first", tick_en, 1);
    for (int k = 1; k <= 5; k++) begin step(1); check("tick_div4", tick_en, k == 5); end
    tick_div = 8'd0;
    step(2);
    for (int k = 0; k < 3; k++) begin step(1); check("tick_div0", tick_en, 1); end
    tick_div = 8'd9;
    n = 0;
    while (!tick_en && n < 12) begin step(1); n++; end
    step(6);
    tick_div = 8'd2;
    step(1); check("tick_shrink", tick_en, 1);
    step(1); check("tick_after1", tick_en, 0);
    step(1); check("tick_after2", tick_en, 0);
    step(1); check("tick_after3", tick_en, 1);
    tick_div = 8'd4;
    // main mission: two waypoints written while paused in IDLE
    wr(10, 20, 1);
    wr(-5, 7, 1);
    check("wp_count2", wp_count, 2);
    check("idle_hold", state, 0);
`ifdef LOOP_MISSION_EN
    begin tgt_t t; t.x = 10; t.y = 20; sb.push_back(t); end
`endif
    robot_enable = 1'b1;
    step(1);
    check("cfg_state", state, 1);
    check("cfg_req_hi", cfg_req, 1);
    step(2);
    cfg_done = 1'b1;
    step(1);
    cfg_done = 1'b0;
    check("gyro_state", state, 2);
    check("cfg_req_drop", cfg_req, 0);
    check("gyro_en_hi", gyro_en, 1);
    wait_state("run1", 4);
    expect_target("wp0");
    check("run1_ctrl", ctrl_en, 1);
    check("run1_telem", telem_en, 1);
    check("run1_idx", wp_index, 0);
    robot_enable = 1'b0;
    step(2);
    check("pause_ctrl", ctrl_en, 0);
    pulse_tr();
    step(7);
    check("pause_state", state, 4);
    check("pause_idx", wp_index, 0);
    check("pause_gyro", gyro_en, 1);
    check("pause_telem", telem_en, 1);
    robot_enable = 1'b1;
    step(1);
    check("resume_ctrl", ctrl_en, 1);
    check("resume_state", state, 4);
    pulse_tr();
    check("edge1_state", state, 3);
    check("edge1_idx", wp_index, 1);
    wait_state("run2", 4);
    expect_target("wp1");
    pulse_tr();
    check("edge2_state", state, 3);
`ifdef LOOP_MISSION_EN
    wait_state("run3", 4);
    expect_target("wrap0");
    check("loop_idx", wp_index, 0);
    check("loop_not_done", mission_done, 0);
`else
    check("edge2_idx", wp_index, 2);
    step(1);
    check("done_state", state, 5);
    check("done_flag", mission_done, 1);
    check("done_idx", wp_index, 2);
    check("done_ctrl", ctrl_en, 0);
    check("done_gyro", gyro_en, 0);
    check("done_telem", telem_en, 1);
    step(3);
    check("done_terminal", state, 5);
`endif
    // overflow: five writes into a four-deep buffer, reset mid-mission first
    do_reset();
    check("rerst_count", wp_count, 0);
    check("rerst_state", state, 0);
    check("rerst_target", target_x, 0);
    sb.delete();
    for (int i = 1; i <= 4; i++) wr(i, -i, 1);
    wr(99, 99, 0);
    check("ovf_count", wp_count, 4);
    check("ovf_flag", wp_overflow, 1);
`ifdef LOOP_MISSION_EN
    begin tgt_t t; t.x = 1; t.y = -1; sb.push_back(t); end
`endif
    gyro_delay = 32'd0;
    cfg_done = 1'b1;
    robot_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_state("ovf_run", 4);
      expect_target("ovf_wp");
      pulse_tr();
    end
`ifdef LOOP_MISSION_EN
    wait_state("ovf_wrap", 4);
    expect_target("ovf_wrap");
    check("ovf_loop_done", mission_done, 0);
`else
    wait_state("ovf_done", 5);
    check("ovf_sb_drained", sb.size(), 0);
`endif
    check("ovf_sticky", wp_overflow, 1);
    // abort coincident with a target_reached edge
    do_reset();
    sb.delete();
    wr(3, 4, 1);
    wr(5, 6, 0);
    cfg_done = 1'b1;
    robot_enable = 1'b1;
    wait_state("abort_run", 4);
    expect_target("abort_wp");
    abort = 1'b1;
    target_reached = 1'b1;
    step(1);
    abort = 1'b0;
    target_reached = 1'b0;
    check("abort_state", state, 5);
    check("abort_count", wp_count, 0);
    check("abort_idx", wp_index, 0);
    check("abort_done", mission_done, 1);
    wr(8, 8, 0);
    check("done_wr_ignored", wp_count, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
